// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the single-clock FIFO.
// DEPTH, pointer and count widths are all derived from ADDRSIZE.
package sync_fifo_pkg;

    // Encodes which sides of the FIFO accept an operation in a given cycle.
    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpWrite = 2'b01,
        OpRead  = 2'b10,
        OpBoth  = 2'b11
    } fifo_op_e;

    function automatic int unsigned depth_of(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned addrsize);
        return addrsize + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned addrsize);
        return addrsize + 1;
    endfunction

    function automatic bit afull_ok(input int unsigned addrsize, input int unsigned thresh);
        return (thresh >= 1) && (thresh <= depth_of(addrsize));
    endfunction

    function automatic bit aempty_ok(input int unsigned addrsize, input int unsigned thresh);
        return thresh <= depth_of(addrsize) - 1;
    endfunction

endpackage

// File: rtl/fifomem_sync.sv
// Dual-port storage array: synchronous write, registered synchronous read.
// Kept standalone so a vendor RAM macro can be dropped in its place.
module fifomem_sync #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                ren,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [DATASIZE-1:0] rdata_q;

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (ren) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: binary wrap-bit pointers, occupancy counter, registered
// full/empty/almost flags, registered read data with valid strobe, sticky errors.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATASIZE      = 8,
    parameter int unsigned ADDRSIZE      = 4,
    parameter int unsigned AFULL_THRESH  = 14,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    output logic                wafull,
    output logic                raempty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                err_clr
);

    localparam int unsigned DEPTH = depth_of(ADDRSIZE);
    localparam int unsigned PTRW  = ptr_width(ADDRSIZE);
    localparam int unsigned CNTW  = cnt_width(ADDRSIZE);

    localparam logic [CNTW-1:0] CntFull   = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CntAfull  = CNTW'(AFULL_THRESH);
    localparam logic [CNTW-1:0] CntAempty = CNTW'(AEMPTY_THRESH);

    initial begin
        if (!afull_ok(ADDRSIZE, AFULL_THRESH)) begin
            $error("sync_fifo: AFULL_THRESH=%0d outside 1..%0d", AFULL_THRESH, DEPTH);
        end
        if (!aempty_ok(ADDRSIZE, AEMPTY_THRESH)) begin
            $error("sync_fifo: AEMPTY_THRESH=%0d outside 0..%0d", AEMPTY_THRESH, DEPTH - 1);
        end
    end

    logic [PTRW-1:0] wptr_q, wptr_d;
    logic [PTRW-1:0] rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            wfull_q, wfull_d;
    logic            rempty_q, rempty_d;
    logic            wafull_q, wafull_d;
    logic            raempty_q, raempty_d;
    logic            rvalid_q;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic     wr_accept;
    logic     rd_accept;
    fifo_op_e op;

    // Acceptance uses this cycle's registered flags: no full-bypass, no forwarding.
    assign wr_accept = winc && !wfull_q;
    assign rd_accept = rinc && !rempty_q;
    assign op        = fifo_op_e'({rd_accept, wr_accept});

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        unique case (op)
            OpWrite: begin
                wptr_d  = wptr_q + PTRW'(1);
                count_d = count_q + CNTW'(1);
            end
            OpRead: begin
                rptr_d  = rptr_q + PTRW'(1);
                count_d = count_q - CNTW'(1);
            end
            OpBoth: begin
                wptr_d = wptr_q + PTRW'(1);
                rptr_d = rptr_q + PTRW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        wfull_d   = (count_d == CntFull);
        rempty_d  = (count_d == '0);
        wafull_d  = (count_d >= CntAfull);
        raempty_d = (count_d <= CntAempty);
    end

    // A set condition in the same cycle as err_clr leaves the flag set.
    always_comb begin
        overflow_d  = (winc && wfull_q) || (overflow_q && !err_clr);
        underflow_d = (rinc && rempty_q) || (underflow_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wfull_q     <= 1'b0;
            rempty_q    <= 1'b1;
            wafull_q    <= 1'b0;
            raempty_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            wfull_q     <= wfull_d;
            rempty_q    <= rempty_d;
            wafull_q    <= wafull_d;
            raempty_q   <= raempty_d;
            rvalid_q    <= rd_accept;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifomem_sync #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .wen   (wr_accept && !rst),
        .waddr (wptr_q[ADDRSIZE-1:0]),
        .wdata (wdata),
        .ren   (rd_accept && !rst),
        .raddr (rptr_q[ADDRSIZE-1:0]),
        .rdata (rdata)
    );

    assign rvalid    = rvalid_q;
    assign wfull     = wfull_q;
    assign rempty    = rempty_q;
    assign wafull    = wafull_q;
    assign raempty   = raempty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table for fill/drain/error/wrap traffic,
// then hand-written sequences for full simultaneous access and mid-run reset.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst, winc, rinc, err_clr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid, wfull, rempty, wafull, raempty, overflow, underflow;
    logic [4:0] count;

    int n_checks = 0;
    int n_pass   = 0;
    int vec_no   = 0;

    typedef struct {
        logic       rst;
        logic       winc;
        logic [7:0] wdata;
        logic       rinc;
        logic       clr;
        int         cnt;
        logic       rv;
        logic [7:0] rd;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vq[$];

    sync_fifo #(
        .DATASIZE      (8),
        .ADDRSIZE      (4),
        .AFULL_THRESH  (14),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .winc      (winc),
        .wdata     (wdata),
        .rinc      (rinc),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .wfull     (wfull),
        .rempty    (rempty),
        .wafull    (wafull),
        .raempty   (raempty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic w, input logic [7:0] wd, input logic rd_en,
                       input logic c, input int cnt, input logic rv, input logic [7:0] rd,
                       input logic ovf, input logic udf);
        vec_t v;
        v.rst = r; v.winc = w; v.wdata = wd; v.rinc = rd_en; v.clr = c;
        v.cnt = cnt; v.rv = rv; v.rd = rd; v.ovf = ovf; v.udf = udf;
        vq.push_back(v);
    endtask

    // Drive one cycle, then compare every output 1 ns after the edge.
    task automatic apply(input vec_t v);
        logic [19:0] got, exp;
        rst = v.rst; winc = v.winc; wdata = v.wdata; rinc = v.rinc; err_clr = v.clr;
        @(posedge clk);
        #1;
        got = {count, wfull, rempty, wafull, raempty, rvalid, overflow, underflow, rdata};
        exp = {5'(v.cnt), v.cnt == 16, v.cnt == 0, v.cnt >= 14, v.cnt <= 2,
               v.rv, v.ovf, v.udf, v.rd};
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL vec%0d got cnt=%0d full=%b empty=%b af=%b ae=%b rv=%b ovf=%b udf=%b rd=%h | required cnt=%0d full=%b empty=%b af=%b ae=%b rv=%b ovf=%b udf=%b rd=%h",
                     vec_no, got[19:15], got[14], got[13], got[12], got[11], got[10], got[9],
                     got[8], got[7:0], exp[19:15], exp[14], exp[13], exp[12], exp[11],
                     exp[10], exp[9], exp[8], exp[7:0]);
        end
        vec_no++;
    endtask

    task automatic step(input logic r, input logic w, input logic [7:0] wd, input logic rd_en,
                        input logic c, input int cnt, input logic rv, input logic [7:0] rd,
                        input logic ovf, input logic udf);
        vec_t v;
        v.rst = r; v.winc = w; v.wdata = wd; v.rinc = rd_en; v.clr = c;
        v.cnt = cnt; v.rv = rv; v.rd = rd; v.ovf = ovf; v.udf = udf;
        apply(v);
    endtask

    initial begin
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = 8'h00;

        // Reset state.
        add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
        // Fill 0x01..0x10.
        for (int i = 1; i <= 16; i++) add(0, 1, 8'(i), 0, 0, i, 0, 8'h00, 0, 0);
        // Write while full: rejected, overflow sticks.
        add(0, 1, 8'hAA, 0, 0, 16, 0, 8'h00, 1, 0);
        // Drain in order, one cycle latency.
        for (int i = 1; i <= 16; i++) add(0, 0, 8'h00, 1, 0, 16 - i, 1, 8'(i), 1, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 8'h10, 1, 0);
        // Underflow, err_clr racing a set, then a plain clear.
        add(0, 0, 8'h00, 1, 0, 0, 0, 8'h10, 1, 1);
        add(0, 0, 8'h00, 1, 1, 0, 0, 8'h10, 0, 1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 8'h10, 0, 0);
        // Hold count at 5 with simultaneous access across the pointer wrap.
        for (int i = 0; i < 5; i++) add(0, 1, 8'(8'h20 + i), 0, 0, i + 1, 0, 8'h10, 0, 0);
        for (int k = 0; k < 20; k++) add(0, 1, 8'(8'h25 + k), 1, 0, 5, 1, 8'(8'h20 + k), 0, 0);
        for (int j = 0; j < 5; j++) add(0, 0, 8'h00, 1, 0, 4 - j, 1, 8'(8'h34 + j), 0, 0);

        foreach (vq[i]) apply(vq[i]);

        // Full FIFO with winc+rinc together: only the read is accepted.
        for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h40 + i), 0, 0, i + 1, 0, 8'h38, 0, 0);
        step(0, 1, 8'hEE, 1, 0, 15, 1, 8'h40, 1, 0);
        for (int i = 1; i <= 15; i++) step(0, 0, 8'h00, 1, 0, 15 - i, 1, 8'(8'h40 + i), 1, 0);
        step(0, 0, 8'h00, 0, 1, 0, 0, 8'h4F, 0, 0);

        // Reset while reading a partly full FIFO cancels the read and drops contents.
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h60 + i), 0, 0, i + 1, 0, 8'h4F, 0, 0);
        step(1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h77, 0, 0, 1, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0, 0, 1, 8'h77, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0, 0, 8'h77, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
